// File: rtl/vdp_sprite_update_scheduler.sv
// rtl/vdp_sprite_update_scheduler.sv - queues sprite writes and applies them only during vblank
module vdp_sprite_update_scheduler #(
  parameter int N_SPRITES          = 8,
  parameter int SPRITE_INDEX_WIDTH = 3,
  parameter int ROW_INDEX_WIDTH    = 3,
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int FIFO_PTR_WIDTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [SPRITE_INDEX_WIDTH-1:0] cmd_sprite,
  input  logic                          cmd_is_xy,
  input  logic [ROW_INDEX_WIDTH-1:0]    cmd_row,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic                          vblank,
  input  logic                          clear_overflow,
  output logic [N_SPRITES-1:0]          xy_we,
  output logic [N_SPRITES-1:0]          row_we,
  output logic [ROW_INDEX_WIDTH-1:0]    wr_row_index,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [FIFO_PTR_WIDTH:0]       pending,
  output logic                          overflow,
  output logic                          busy
);

  typedef enum logic {ST_HOLD, ST_DRAIN} state_t;

  localparam int ENTRY_W = SPRITE_INDEX_WIDTH + 1 + ROW_INDEX_WIDTH + DATA_WIDTH;
  localparam logic [FIFO_PTR_WIDTH:0] DEPTH_C = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0]            mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_WIDTH-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR_WIDTH:0]       count_q, count_d;
  state_t                        state_q, state_d;
  logic                          overflow_q, overflow_d;
  logic [N_SPRITES-1:0]          xy_we_q, xy_we_d, row_we_q, row_we_d;
  logic [ROW_INDEX_WIDTH-1:0]    wr_row_q, wr_row_d;
  logic [DATA_WIDTH-1:0]         wr_data_q, wr_data_d;

  logic                          full, empty, push, pop;
  logic [ENTRY_W-1:0]            rd_entry;
  logic [SPRITE_INDEX_WIDTH-1:0] rd_sprite;
  logic                          rd_is_xy;
  logic [ROW_INDEX_WIDTH-1:0]    rd_row;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic [N_SPRITES-1:0]          rd_onehot;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == ST_DRAIN) && vblank && !empty;

  assign rd_entry = mem_q[rd_ptr_q];
  assign {rd_sprite, rd_is_xy, rd_row, rd_data} = rd_entry;

  always_comb begin
    rd_onehot = '0;
    // Out-of-range sprite indices are consumed silently.
    if (32'(rd_sprite) < N_SPRITES) rd_onehot = N_SPRITES'(1) << rd_sprite;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (cmd_valid && full) overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:  if (vblank && !empty) state_d = ST_DRAIN;
      ST_DRAIN: if (!vblank || count_d == '0) state_d = ST_HOLD;
      default:  state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    xy_we_d  = '0;
    row_we_d = '0;
    wr_row_d = wr_row_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      if (rd_is_xy) xy_we_d = rd_onehot;
      else          row_we_d = rd_onehot;
      wr_row_d  = rd_row;
      wr_data_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_sprite, cmd_is_xy, cmd_row, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_HOLD;
      overflow_q <= 1'b0;
      xy_we_q    <= '0;
      row_we_q   <= '0;
      wr_row_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      xy_we_q    <= xy_we_d;
      row_we_q   <= row_we_d;
      wr_row_q   <= wr_row_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign cmd_ready    = !full;
  assign xy_we        = xy_we_q;
  assign row_we       = row_we_q;
  assign wr_row_index = wr_row_q;
  assign wr_data      = wr_data_q;
  assign pending      = count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_vdp_sprite_update_scheduler.sv
// tb/tb_vdp_sprite_update_scheduler.sv - vector, scenario and random checks against a queue model
module tb_vdp_sprite_update_scheduler;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_is_xy, vblank, clear_overflow, overflow, busy;
  logic [2:0]  cmd_sprite, cmd_row, wr_row_index;
  logic [31:0] cmd_data, wr_data;
  logic [7:0]  xy_we, row_we;
  logic [4:0]  pending;

  vdp_sprite_update_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sprite(cmd_sprite), .cmd_is_xy(cmd_is_xy), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .vblank(vblank), .clear_overflow(clear_overflow), .xy_we(xy_we), .row_we(row_we),
    .wr_row_index(wr_row_index), .wr_data(wr_data), .pending(pending),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sprite;
    logic        is_xy;
    logic [2:0]  row;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    ent_t       cmd;
    logic [7:0] exp_xy;
    logic [7:0] exp_row;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of accepted commands plus a draining flag.
  ent_t        mq[$];
  bit          m_drain, m_over;
  logic [7:0]  e_xy, e_row;
  logic [2:0]  e_idx;
  logic [31:0] e_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    ent_t e;
    int   sz0;
    bit   full;
    sz0 = mq.size();
    if (reset) begin
      mq.delete();
      m_drain = 0; m_over = 0;
      e_xy = '0; e_row = '0; e_idx = '0; e_data = '0;
      return;
    end
    full = (sz0 == 16);
    e_xy = '0; e_row = '0;
    if (m_drain && vblank && sz0 != 0) begin
      e = mq.pop_front();
      if (e.is_xy) e_xy[e.sprite] = 1'b1;
      else         e_row[e.sprite] = 1'b1;
      e_idx = e.row;
      e_data = e.data;
    end
    if (cmd_valid && !full) mq.push_back({cmd_sprite, cmd_is_xy, cmd_row, cmd_data});
    if (cmd_valid && full) m_over = 1;
    else if (clear_overflow) m_over = 0;
    if (!m_drain) m_drain = vblank && sz0 != 0;
    else          m_drain = vblank && mq.size() != 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("xy_we", xy_we, e_xy);
    chk("row_we", row_we, e_row);
    chk("wr_row_index", wr_row_index, e_idx);
    chk("wr_data", wr_data, e_data);
    chk("pending", pending, mq.size());
    chk("overflow", overflow, m_over);
    chk("busy", busy, m_drain);
    chk("cmd_ready", cmd_ready, mq.size() < 16);
  endtask

  task automatic push(input logic [2:0] s, input logic x, input logic [2:0] r, input logic [31:0] d);
    cmd_sprite = s; cmd_is_xy = x; cmd_row = r; cmd_data = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic bit any_we();
    return (|xy_we) || (|row_we);
  endfunction

  vec_t vecs[6];

  initial begin
    int en, rest, lat, nxt;
    logic [4:0] p_ref;
    bit first;

    reset = 1'b1; cmd_valid = 1'b0; cmd_sprite = '0; cmd_is_xy = 1'b0; cmd_row = '0;
    cmd_data = '0; vblank = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_xy_we", xy_we, 8'h00);
    chk("rst_row_we", row_we, 8'h00);
    chk("rst_pending", pending, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_wr_data", wr_data, 32'h0);

    vecs[0] = '{'{3'd2, 1'b1, 3'd0, 32'h00640032}, 8'h04, 8'h00};
    vecs[1] = '{'{3'd5, 1'b0, 3'd3, 32'hFFFF0000}, 8'h00, 8'h20};
    vecs[2] = '{'{3'd7, 1'b1, 3'd0, 32'h00000001}, 8'h80, 8'h00};
    vecs[3] = '{'{3'd0, 1'b0, 3'd7, 32'hA5A5A5A5}, 8'h00, 8'h01};
    vecs[4] = '{'{3'd3, 1'b1, 3'd5, 32'h12345678}, 8'h08, 8'h00};
    vecs[5] = '{'{3'd6, 1'b0, 3'd1, 32'hDEADBEEF}, 8'h00, 8'h40};

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].cmd.sprite, vecs[i].cmd.is_xy, vecs[i].cmd.row, vecs[i].cmd.data);
      chk("vec_hold_no_we", any_we(), 1'b0);
    end
    chk("vec_pending", pending, 5'd6);
    chk("vec_busy_idle", busy, 1'b0);
    vblank = 1'b1;
    tick();
    chk("vec_busy_up", busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("vec_xy_we", xy_we, vecs[i].exp_xy);
      chk("vec_row_we", row_we, vecs[i].exp_row);
      chk("vec_wr_data", wr_data, vecs[i].cmd.data);
      if (!vecs[i].cmd.is_xy) chk("vec_row_index", wr_row_index, vecs[i].cmd.row);
    end
    chk("vec_pending_end", pending, 5'd0);
    chk("vec_busy_end", busy, 1'b0);
    vblank = 1'b0;
    tick();

    for (int k = 0; k < 17; k++) begin
      push(3'(k), k[0], 3'(k), 32'(100 + k));
      if (k == 15) chk("fill_ready_low", cmd_ready, 1'b0);
    end
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_pending", pending, 5'd16);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear_overflow", overflow, 1'b0);

    vblank = 1'b1;
    en = 0;
    repeat (10) begin tick(); if (any_we()) en++; end
    vblank = 1'b0;
    tick();
    if (any_we()) en++;
    chk("partial_at_most_10", en <= 10, 1'b1);
    chk("partial_pending", pending, 5'(16 - en));
    rest = 0;
    repeat (3) begin tick(); if (any_we()) rest++; end
    chk("partial_quiet", rest, 0);
    vblank = 1'b1;
    first = 1'b1;
    rest = 0;
    repeat (25) begin
      tick();
      if (any_we()) begin
        if (first) chk("partial_resume_order", wr_data, 32'(100 + en));
        first = 1'b0;
        rest++;
      end
    end
    chk("partial_rest_count", rest, 16 - en);
    vblank = 1'b0;
    tick();

    vblank = 1'b1;
    tick();
    push(3'd4, 1'b1, 3'd0, 32'h0000BEEF);
    lat = -1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (any_we() && lat < 0) lat = j;
    end
    chk("latency", lat, 2);

    nxt = 200;
    p_ref = '0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 22; k++) begin
      cmd_sprite = 3'(k); cmd_is_xy = ~k[0]; cmd_row = 3'(k + 1); cmd_data = 32'(200 + k);
      tick();
      if (k == 3) p_ref = pending;
      if (k > 3) chk("stream_pending_const", pending, p_ref);
      if (any_we()) begin chk("stream_order", wr_data, 32'(nxt)); nxt++; end
    end
    cmd_valid = 1'b0;
    repeat (6) begin
      tick();
      if (any_we()) begin chk("stream_order", wr_data, 32'(nxt)); nxt++; end
    end
    chk("stream_all_issued", nxt, 222);
    vblank = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) push(3'(k), 1'b0, 3'(7 - k), 32'(300 + k));
    vblank = 1'b1;
    tick();
    chk("rstmid_pending", pending, 5'd8);
    chk("rstmid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_no_we", any_we(), 1'b0);
    chk("rstmid_pending0", pending, 5'd0);
    chk("rstmid_busy0", busy, 1'b0);
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    rest = 0;
    repeat (5) begin tick(); if (any_we()) rest++; end
    chk("rstmid_no_stale", rest, 0);
    vblank = 1'b0;
    tick();

    for (int k = 0; k < 16; k++) push(3'(k), 1'b1, 3'd0, 32'(400 + k));
    chk("fullpop_ready_low", cmd_ready, 1'b0);
    vblank = 1'b1;
    tick();
    chk("fullpop_still_full", pending, 5'd16);
    push(3'd1, 1'b1, 3'd1, 32'hBAD0BAD0);
    chk("fullpop_overflow", overflow, 1'b1);
    chk("fullpop_pending", pending, 5'd15);
    repeat (18) tick();
    vblank = 1'b0;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom_range(0, 99) < 55);
      cmd_sprite = 3'($urandom);
      cmd_is_xy = 1'($urandom);
      cmd_row = 3'($urandom);
      cmd_data = $urandom;
      if ($urandom_range(0, 99) < 6) vblank = ~vblank;
      clear_overflow = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 999) < 4);
      tick();
    end
    reset = 1'b0; cmd_valid = 1'b0; clear_overflow = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
